// File: rtl/reg_arb_pkg.sv
// Shared types for reg_write_arbiter: FSM state encoding and index-width helper.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_e;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]      req,
  input  logic [idw(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]      gnt,
  output logic [idw(N_REQ)-1:0] idx,
  output logic                  any
);

  localparam int IDW = idw(N_REQ);

  int            j;
  logic [IDW-1:0] jj;

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    jj  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j  = (int'(ptr) + k) % N_REQ;
      jj = IDW'(j);
      if (req[jj]) begin
        gnt     = '0;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter owning a shared DW-bit register (IDLE -> WRITE -> ACK).
// Optional back-to-back locked writes are enabled by defining REG_ARB_LOCK_EN.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int             N_REQ    = 4,
  parameter int             DW       = 8,
  parameter logic [DW-1:0]  RST_VAL  = '0,
  parameter int             MAX_LOCK = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DW-1:0]   wdata,
`ifdef REG_ARB_LOCK_EN
  input  logic [N_REQ-1:0]      lock,
`endif
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      ack,
  output logic                  reg_en,
  output logic [DW-1:0]         reg_data,
  output logic [DW-1:0]         q,
  output logic                  busy,
  output logic [idw(N_REQ)-1:0] last_id
);

  localparam int IDW = idw(N_REQ);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] w_q, w_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] last_q, last_d;
  logic [DW-1:0]  data_q, data_d;
  logic [DW-1:0]  q_q, q_d;

  logic [DW-1:0]    wd [N_REQ];
  logic [N_REQ-1:0] pick_gnt;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [DW-1:0]    pick_data;
  logic [N_REQ-1:0] w_oh;
  logic [IDW-1:0]   ptr_nxt;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign wd[i] = wdata[i*DW +: DW];
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) pick_data = wd[i];
    end
    w_oh      = '0;
    w_oh[w_q] = 1'b1;
    ptr_nxt   = (w_q == IDW'(N_REQ - 1)) ? '0 : w_q + 1'b1;
  end

`ifdef REG_ARB_LOCK_EN
  localparam int LCW = idw(MAX_LOCK);
  logic [LCW-1:0] lcnt_q, lcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    data_d  = data_q;
    q_d     = q_q;
`ifdef REG_ARB_LOCK_EN
    lcnt_d  = lcnt_q;
`endif
    gnt     = '0;
    ack     = '0;
    reg_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          w_d     = pick_idx;
          data_d  = pick_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        gnt     = w_oh;
        reg_en  = 1'b1;
        q_d     = data_q;
        last_d  = w_q;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        ack = w_oh;
`ifdef REG_ARB_LOCK_EN
        // A locked winner keeps the slot, bounded so others are not starved.
        if (lock[w_q] && req[w_q] && (lcnt_q < LCW'(MAX_LOCK - 1))) begin
          data_d  = wd[w_q];
          lcnt_d  = lcnt_q + 1'b1;
          state_d = ST_WRITE;
        end else begin
          ptr_d   = ptr_nxt;
          lcnt_d  = '0;
          state_d = ST_IDLE;
        end
`else
        ptr_d   = ptr_nxt;
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      ptr_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
      q_q     <= RST_VAL;
`ifdef REG_ARB_LOCK_EN
      lcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      data_q  <= data_d;
      q_q     <= q_d;
`ifdef REG_ARB_LOCK_EN
      lcnt_q  <= lcnt_d;
`endif
    end
  end

  assign reg_data = data_q;
  assign q        = q_q;
  assign busy     = (state_q != ST_IDLE);
  assign last_id  = last_q;

endmodule
